rv_reset_sequencer: RTL and testbench
=====================================

// Module: rv_reset_sequencer
// PURPOSE
//  Parametrised reset sequencer for the RISC-V datapath and its peripherals. Takes the single
//  system reset and releases N reset domains in staggered order after a programmable hold time.
//  Also supports software-requested re-reset from the running core, with a saturating event count.
//  Sits between the top-level clk/reset pins and the reset inputs of datapath_RISCV and its neighbours.
// PARAMETERS
//  N_DOMAINS       4   number of reset domains driven; >= 1
//  HOLD_CYCLES     2   cycles all domains stay asserted after the sequence starts; >= 1
//  STAGGER_CYCLES  1   cycles between releasing domain i and domain i+1; >= 1
//  CNT_W           8   width of rst_count
//  WDOG_CYCLES     256 heartbeat timeout in cycles (used only with RST_SEQ_WDOG_EN)
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  reset         in   1          synchronous, active-high system reset
//  sw_rst_req    in   1          1-cycle pulse: restart the sequence
//  domain_rst    out  N_DOMAINS  per-domain reset, active-high; bit 0 released first
//  all_released  out  1          1 when every domain_rst bit is 0
//  busy          out  1          1 while the sequence is in progress (ASSERT or RELEASE)
//  rst_count     out  CNT_W      number of sequences restarted since reset; saturating
//  heartbeat     in   1          (RST_SEQ_WDOG_EN only) core liveness pulse
//  wdog_fired    out  1          (RST_SEQ_WDOG_EN only) sticky watchdog-trigger flag
// BEHAVIOUR
//  - Reset values (while reset=1): domain_rst='1, all_released=0, busy=1, rst_count=0,
//    wdog_fired=0, state=ASSERT, timers cleared.
//  - FSM states:
//    - ASSERT: domain_rst='1. Stays here for HOLD_CYCLES edges, then goes to RELEASE.
//    - RELEASE: clears one bit, lowest index first, every STAGGER_CYCLES edges.
//      After the last bit clears, goes to RUN.
//    - RUN: domain_rst=0, all_released=1, busy=0.
//  - Timing: E0 is the first posedge that samples reset=0.
//    Bit i reads 0 after edge E(HOLD_CYCLES + i*STAGGER_CYCLES).
//    all_released rises on the same edge as the last bit clears, and busy falls on that same edge.
//  - sw_rst_req while in RUN: on the next edge, domain_rst='1, state=ASSERT, busy=1,
//    all_released=0, rst_count+1. That edge counts as E0 for the new sequence.
//  - sw_rst_req while in ASSERT or RELEASE: restarts from ASSERT and re-asserts any bits
//    already released. rst_count+1.
//  - rst_count saturates at 2**CNT_W-1. Only reset clears it.
//  - reset overrides everything, including a request or watchdog event in the same cycle.
//    reset mid-sequence returns to reset values immediately.
//  - domain_rst bits are monotonic within a sequence: once released, a bit stays 0 until the
//    next restart.
// CONFIGURATION
//  - `RST_SEQ_WDOG_EN defined:
//    - The heartbeat and wdog_fired ports exist.
//    - In RUN, a timer counts cycles since the last heartbeat; a heartbeat reloads it.
//    - If WDOG_CYCLES elapse with no heartbeat: the sequence restarts exactly as for
//      sw_rst_req, rst_count+1, and wdog_fired is set (sticky until reset).
//    - The timer is held cleared outside RUN.
//    - If sw_rst_req and the timeout occur on the same edge: one restart, rst_count+1,
//      and wdog_fired is set.
//  - `RST_SEQ_WDOG_EN undefined: those ports and the timer are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Package rv_rst_pkg holds:
//    - typedef enum logic [1:0] {ASSERT, RELEASE, RUN} rst_state_t;
//    - default localparams for HOLD/STAGGER/WDOG widths.
//  - Sub-module rst_seq_timer: loadable down-counter with a zero flag. It is instantiated
//    for the hold/stagger timing and, when `RST_SEQ_WDOG_EN is defined, for the watchdog.
//  - Top level holds the FSM, domain shift register, and saturating counter.
// TESTING
//  1. Defaults. Reset high for 2 edges, then low. Expect:
//     domain_rst 1111 through E1; 1110 @E2, 1100 @E3, 1000 @E4, 0000 @E5;
//     all_released=1 and busy=0 @E5.
//  2. HOLD_CYCLES=3, STAGGER_CYCLES=2, N_DOMAINS=2. Expect bit0 low @E3, bit1 low @E5.
//  3. sw_rst_req pulse in RUN. Expect domain_rst=1111, busy=1, rst_count=1 next edge;
//     release pattern then repeats as in test 1.
//  4. sw_rst_req @E3 (domain_rst=1110, mid-RELEASE). Expect 1111 next edge, full hold
//     restarts, rst_count=1. Then CNT_W=2 with 5 requests: rst_count saturates at 3.
//  5. Reset asserted mid-RELEASE with sw_rst_req high in the same cycle.
//     Expect reset values; rst_count=0.
//  6. `RST_SEQ_WDOG_EN, WDOG_CYCLES=8, no heartbeat in RUN. Expect restart 8 cycles after
//     entering RUN, with wdog_fired=1 and rst_count=1. With heartbeat every 4 cycles:
//     no restart for 100 cycles.

Source files
------------

// File: rtl/rv_rst_pkg.sv
// Shared types and defaults for the RISC-V reset sequencer.
package rv_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_state_t;

    localparam int unsigned DEF_HOLD_CYCLES    = 2;
    localparam int unsigned DEF_STAGGER_CYCLES = 1;
    localparam int unsigned DEF_WDOG_CYCLES    = 256;

    // Bits needed to hold max_val; never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module rst_seq_timer #(
    parameter int unsigned  W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rv_reset_sequencer.sv
// Staggered multi-domain reset release with software re-reset and saturating restart count.
// Optional heartbeat watchdog enabled by defining RST_SEQ_WDOG_EN.
module rv_reset_sequencer
    import rv_rst_pkg::*;
#(
    parameter int unsigned N_DOMAINS      = 4,
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned WDOG_CYCLES    = DEF_WDOG_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sw_rst_req,
`ifdef RST_SEQ_WDOG_EN
    input  logic                 heartbeat,
    output logic                 wdog_fired,
`endif
    output logic [N_DOMAINS-1:0] domain_rst,
    output logic                 all_released,
    output logic                 busy,
    output logic [CNT_W-1:0]     rst_count,
    output rst_state_t           dbg_state_o
);

    localparam int unsigned SEQ_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int unsigned TMR_W   = cnt_width((SEQ_MAX > WDOG_CYCLES) ? SEQ_MAX : WDOG_CYCLES);

    rst_state_t           state_q, state_d;
    logic [N_DOMAINS-1:0] dom_q, dom_d, dom_shift;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 seq_load, seq_dec, seq_zero;
    logic [TMR_W-1:0]     seq_val;
    logic                 wdog_to;
    logic                 restart;

    // Out of reset the hold timer starts at HOLD_CYCLES because the first
    // unreset edge is itself a hold edge; a restart edge already counts as one.
    rst_seq_timer #(
        .W       (TMR_W),
        .RST_VAL (TMR_W'(HOLD_CYCLES))
    ) u_seq_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (seq_load),
        .load_val_i (seq_val),
        .dec_i      (seq_dec),
        .zero_o     (seq_zero)
    );

`ifdef RST_SEQ_WDOG_EN
    logic wd_load, wd_dec, wd_zero;
    logic wdog_fired_q, wdog_fired_d;

    // Reloaded outside RUN and on every heartbeat; times out only while running.
    assign wd_load = (state_q != RUN) || heartbeat;
    assign wd_dec  = !wd_load;
    assign wdog_to = (state_q == RUN) && !heartbeat && wd_zero;

    rst_seq_timer #(
        .W       (TMR_W),
        .RST_VAL (TMR_W'(WDOG_CYCLES - 1))
    ) u_wdog_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (wd_load),
        .load_val_i (TMR_W'(WDOG_CYCLES - 1)),
        .dec_i      (wd_dec),
        .zero_o     (wd_zero)
    );

    always_comb begin
        wdog_fired_d = wdog_fired_q | wdog_to;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_fired_q <= 1'b0;
        end else begin
            wdog_fired_q <= wdog_fired_d;
        end
    end

    assign wdog_fired = wdog_fired_q;
`else
    assign wdog_to = 1'b0;
`endif

    assign restart = sw_rst_req | wdog_to;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ASSERT;
            dom_q   <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dom_q   <= dom_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        dom_shift = dom_q << 1;
        state_d   = state_q;
        dom_d     = dom_q;
        seq_load  = 1'b0;
        seq_dec   = 1'b0;
        seq_val   = '0;
        cnt_d     = cnt_q;
        if (restart) begin
            state_d  = ASSERT;
            dom_d    = '1;
            seq_load = 1'b1;
            seq_val  = TMR_W'(HOLD_CYCLES - 1);
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            unique case (state_q)
                ASSERT, RELEASE: begin
                    // Lowest still-asserted bit drops each time the timer expires.
                    if (seq_zero) begin
                        dom_d    = dom_shift;
                        seq_load = 1'b1;
                        seq_val  = TMR_W'(STAGGER_CYCLES - 1);
                        state_d  = (dom_shift == '0) ? RUN : RELEASE;
                    end else begin
                        seq_dec = 1'b1;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d  = ASSERT;
                    dom_d    = '1;
                    seq_load = 1'b1;
                    seq_val  = TMR_W'(HOLD_CYCLES - 1);
                end
            endcase
        end
    end

    always_comb begin
        domain_rst   = dom_q;
        all_released = (state_q == RUN);
        busy         = (state_q != RUN);
        rst_count    = cnt_q;
        dbg_state_o  = state_q;
    end

endmodule

// File: tb/tb_rv_reset_sequencer.sv
// Table-driven bench for rv_reset_sequencer: three configurations, plus the watchdog when RST_SEQ_WDOG_EN is defined.
module tb_rv_reset_sequencer;
    import rv_rst_pkg::*;

    typedef struct {
        logic       rst;
        logic       sw;
        logic       hb;
        logic [3:0] dom;
        logic       all_r;
        logic       busy;
        logic [7:0] cnt;
        logic       wd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst = 3'b111;
    logic [2:0] sw  = 3'b000;
    logic [2:0] hb  = 3'b000;

    logic [3:0] d0_dom;  logic d0_all, d0_busy, d0_wd;  logic [7:0] d0_cnt;  rst_state_t d0_st;
    logic [1:0] d1_dom;  logic d1_all, d1_busy, d1_wd;  logic [7:0] d1_cnt;  rst_state_t d1_st;
    logic [3:0] d2_dom;  logic d2_all, d2_busy, d2_wd;  logic [1:0] d2_cnt;  rst_state_t d2_st;

    rv_reset_sequencer #(.WDOG_CYCLES(8)) dut0 (
        .clk(clk), .reset(rst[0]), .sw_rst_req(sw[0]),
`ifdef RST_SEQ_WDOG_EN
        .heartbeat(hb[0]), .wdog_fired(d0_wd),
`endif
        .domain_rst(d0_dom), .all_released(d0_all), .busy(d0_busy),
        .rst_count(d0_cnt), .dbg_state_o(d0_st)
    );

    rv_reset_sequencer #(.N_DOMAINS(2), .HOLD_CYCLES(3), .STAGGER_CYCLES(2)) dut1 (
        .clk(clk), .reset(rst[1]), .sw_rst_req(sw[1]),
`ifdef RST_SEQ_WDOG_EN
        .heartbeat(hb[1]), .wdog_fired(d1_wd),
`endif
        .domain_rst(d1_dom), .all_released(d1_all), .busy(d1_busy),
        .rst_count(d1_cnt), .dbg_state_o(d1_st)
    );

    rv_reset_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(rst[2]), .sw_rst_req(sw[2]),
`ifdef RST_SEQ_WDOG_EN
        .heartbeat(hb[2]), .wdog_fired(d2_wd),
`endif
        .domain_rst(d2_dom), .all_released(d2_all), .busy(d2_busy),
        .rst_count(d2_cnt), .dbg_state_o(d2_st)
    );

`ifndef RST_SEQ_WDOG_EN
    assign d0_wd = 1'b0;
    assign d1_wd = 1'b0;
    assign d2_wd = 1'b0;
`endif

    // Word layout: [16:15] state, [14] wdog_fired, [13:10] domain_rst, [9] all_released, [8] busy, [7:0] rst_count
    logic [16:0] exp_q[$];
    vec_t        tv[$];
    int          checks = 0;
    int          errors = 0;

`ifdef RST_SEQ_WDOG_EN
    localparam logic [16:0] CMP_MASK = 17'h1FFFF;
`else
    localparam logic [16:0] CMP_MASK = 17'h1BFFF;
`endif

    function automatic logic [16:0] actual(input int which);
        case (which)
            0:       return {d0_st, d0_wd, d0_dom, d0_all, d0_busy, d0_cnt};
            1:       return {d1_st, d1_wd, 2'b00, d1_dom, d1_all, d1_busy, d1_cnt};
            default: return {d2_st, d2_wd, d2_dom, d2_all, d2_busy, 6'd0, d2_cnt};
        endcase
    endfunction

    task automatic add(input logic r, input logic s, input logic h, input logic [3:0] d,
                       input logic a, input logic b, input logic [7:0] c, input logic w);
        vec_t v;
        v.rst = r; v.sw = s; v.hb = h; v.dom = d; v.all_r = a; v.busy = b; v.cnt = c; v.wd = w;
        tv.push_back(v);
    endtask

    // Drive one vector before the edge, queue its expectation, compare #1 after the edge.
    task automatic apply(input int which, input int step, input vec_t v);
        logic [16:0] exp_w, act_w;
        logic [3:0]  mask;
        rst_state_t  es;
        mask = (which == 1) ? 4'b0011 : 4'b1111;
        es   = v.all_r ? RUN : ((v.dom == mask) ? ASSERT : RELEASE);
        rst[which] = v.rst;
        sw[which]  = v.sw;
        hb[which]  = v.hb;
        exp_q.push_back({es, v.wd, v.dom, v.all_r, v.busy, v.cnt});
        @(posedge clk);
        #1;
        act_w = actual(which);
        exp_w = exp_q.pop_front();
        checks++;
        if ((act_w & CMP_MASK) != (exp_w & CMP_MASK)) begin
            errors++;
            $display("FAIL dut%0d step %0d: got st=%0d wd=%b dom=%b all=%b busy=%b cnt=%0d, expected st=%0d wd=%b dom=%b all=%b busy=%b cnt=%0d",
                     which, step, act_w[16:15], act_w[14], act_w[13:10], act_w[9], act_w[8], act_w[7:0],
                     exp_w[16:15], exp_w[14], exp_w[13:10], exp_w[9], exp_w[8], exp_w[7:0]);
        end
    endtask

    task automatic run(input int which);
        for (int i = 0; i < tv.size(); i++) begin
            apply(which, i, tv[i]);
        end
        tv.delete();
        sw[which] = 1'b0;
        hb[which] = 1'b0;
    endtask

    // Reset, then the default release pattern E0..E5 with a given count.
    task automatic add_boot(input logic [7:0] c);
        add(1, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1110, 0, 1, c, 0);
        add(0, 0, 0, 4'b1100, 0, 1, c, 0);
        add(0, 0, 0, 4'b1000, 0, 1, c, 0);
        add(0, 0, 0, 4'b0000, 1, 0, c, 0);
    endtask

    initial begin
        int idle;

        // Defaults: reset for two edges, release, then a request from RUN
        add(1, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add_boot(8'd0);
        add(0, 0, 0, 4'b0000, 1, 0, 8'd0, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b1110, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b1100, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b1000, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b0000, 1, 0, 8'd1, 0);
        // Request mid-RELEASE re-asserts released bits and restarts the full hold
        add(1, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1110, 0, 1, 8'd0, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b1110, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b1100, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b1000, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b0000, 1, 0, 8'd1, 0);
        // Reset wins over a same-cycle request mid-RELEASE
        add(0, 1, 0, 4'b1111, 0, 1, 8'd2, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd2, 0);
        add(0, 0, 0, 4'b1110, 0, 1, 8'd2, 0);
        add(0, 0, 0, 4'b1100, 0, 1, 8'd2, 0);
        add(1, 1, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b1110, 0, 1, 8'd0, 0);
        // Requests in RELEASE and then in ASSERT both restart and count
        add(0, 1, 0, 4'b1111, 0, 1, 8'd1, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd2, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd2, 0);
        add(0, 0, 0, 4'b1110, 0, 1, 8'd2, 0);
        run(0);

        // N_DOMAINS=2, HOLD_CYCLES=3, STAGGER_CYCLES=2
        idle = $urandom_range(1, 5);
        add(1, 0, 0, 4'b0011, 0, 1, 8'd0, 0);
        add(1, 0, 0, 4'b0011, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b0011, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b0011, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b0011, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b0010, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b0010, 0, 1, 8'd0, 0);
        add(0, 0, 0, 4'b0000, 1, 0, 8'd0, 0);
        for (int i = 0; i < idle; i++) add(0, 0, 0, 4'b0000, 1, 0, 8'd0, 0);
        add(0, 1, 0, 4'b0011, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b0011, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b0011, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b0010, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b0010, 0, 1, 8'd1, 0);
        add(0, 0, 0, 4'b0000, 1, 0, 8'd1, 0);
        run(1);

        // CNT_W=2: five back-to-back requests saturate the count at 3
        add(1, 0, 0, 4'b1111, 0, 1, 8'd0, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd1, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd2, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd3, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd3, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd3, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd3, 0);
        add(0, 0, 0, 4'b1110, 0, 1, 8'd3, 0);
        add(0, 0, 0, 4'b1100, 0, 1, 8'd3, 0);
        add(0, 0, 0, 4'b1000, 0, 1, 8'd3, 0);
        add(0, 0, 0, 4'b0000, 1, 0, 8'd3, 0);
        add(0, 1, 0, 4'b1111, 0, 1, 8'd3, 0);
        run(2);

`ifdef RST_SEQ_WDOG_EN
        // No heartbeat: timeout on the 8th edge after entering RUN
        add_boot(8'd0);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 4'b0000, 1, 0, 8'd0, 0);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd1, 1);
        add(0, 0, 0, 4'b1111, 0, 1, 8'd1, 1);
        add(0, 0, 0, 4'b1110, 0, 1, 8'd1, 1);
        add(0, 0, 0, 4'b1100, 0, 1, 8'd1, 1);
        add(0, 0, 0, 4'b1000, 0, 1, 8'd1, 1);
        add(0, 0, 0, 4'b0000, 1, 0, 8'd1, 1);
        // Heartbeat every 4 cycles keeps RUN for 100 cycles; reset cleared the sticky flag
        add_boot(8'd0);
        for (int i = 0; i < 100; i++) add(0, 0, ((i % 4) == 0), 4'b0000, 1, 0, 8'd0, 0);
        run(0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
